// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding
// and the fixed frame-format constants.
package loader_pkg;

  // Highest writable CPU memory word address; anything above is a frame error.
  localparam int ADDR_MAX       = 2047;
  // Payload words are carried as 4 big-endian bytes each.
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HDR_A0 = 4'd1,
    HDR_A1 = 4'd2,
    HDR_C0 = 4'd3,
    HDR_C1 = 4'd4,
    DATA   = 4'd5,
    COMMIT = 4'd6,
    CHK    = 4'd7,
    RUN    = 4'd8,
    ERROR  = 4'd9
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Big-endian word assembler: shifts stream bytes in MSB first and flags the
// byte that completes a word. A clear discards any partial word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_byte_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // Next word/index: clear wins over a byte load.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (en_i) begin
      word_d = {word_q[23:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  // Shift register and byte index storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_q;
  // High while the byte about to be loaded is the last of the word.
  assign last_byte_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Parses a framed byte stream
//   start_addr[15:0], word_count[15:0], N x 32-bit big-endian words
// and writes the words into CPU memory, holding the CPU stalled (cpu_en=0)
// until the whole frame has landed.
//
// Optional feature, macro LOADER_CHECKSUM_EN: a trailing byte equal to the
// XOR of all header and payload bytes must follow the payload; a mismatch
// ends in ERROR and the CPU is never released.
//
// Handshake: a byte transfers on a rising edge when in_valid && in_ready;
// in_ready depends only on the current state, never on in_valid, and the
// loader holds any partial word for as long as in_valid stays low.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_req,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              w_enable,
  output logic              cpu_en,
  output logic              busy,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [3:0]        dbg_state
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e DONE_ST = CHK;
`else
  localparam state_e DONE_ST = RUN;
`endif

  state_e             state_q, state_d;
  logic [7:0]         start_hi_q, start_hi_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [7:0]         cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  wadr_q, wadr_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  logic               accept;
  logic               load_start;
  logic [15:0]        hdr_addr;
  logic [CNT_W-1:0]   hdr_cnt;
  logic [CNT_W:0]     addr_sum;
  logic               addr_over;
  logic [CNT_W-1:0]   idx_inc;
  logic               commit_ok;
  logic [31:0]        asm_word;
  logic               asm_last;

  assign accept     = in_valid && in_ready;
  // load_req is honoured only outside the load states.
  assign load_start = load_req && (state_q == IDLE || state_q == RUN || state_q == ERROR);
  assign hdr_addr   = {start_hi_q, in_data};
  assign hdr_cnt    = CNT_W'({cnt_hi_q, in_data});
  // Widened sum so start+i past the top of memory is visible, not wrapped.
  assign addr_sum   = {{(CNT_W + 1 - ADDR_W){1'b0}}, start_q} + {1'b0, idx_q};
  assign addr_over  = addr_sum > (CNT_W + 1)'(ADDR_MAX);
  assign idx_inc    = idx_q + CNT_W'(1);
  assign commit_ok  = (state_q == COMMIT) && !addr_over;

  word_assembler u_asm (
    .clk         (clk),
    .rst_n       (resetn),
    .clr_i       (load_start),
    .en_i        (accept && (state_q == DATA)),
    .byte_i      (in_data),
    .word_o      (asm_word),
    .last_byte_o (asm_last)
  );

  // Next-state logic for the frame parser and its datapath registers.
  always_comb begin
    state_d    = state_q;
    start_hi_d = start_hi_q;
    start_d    = start_q;
    cnt_hi_d   = cnt_hi_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    words_d    = words_q;
    err_d      = err_q;
    wadr_d     = wadr_q;
    wdat_d     = wdat_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    if (accept && state_q != CHK) chk_d = chk_q ^ in_data;
`endif
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (load_req) begin
          state_d = HDR_A0;
          err_d   = 1'b0;
          words_d = '0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      HDR_A0: begin
        if (accept) begin
          start_hi_d = in_data;
          state_d    = HDR_A1;
        end
      end
      HDR_A1: begin
        if (accept) begin
          if (hdr_addr > 16'(ADDR_MAX)) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            start_d = hdr_addr[ADDR_W-1:0];
            state_d = HDR_C0;
          end
        end
      end
      HDR_C0: begin
        if (accept) begin
          cnt_hi_d = in_data;
          state_d  = HDR_C1;
        end
      end
      HDR_C1: begin
        if (accept) begin
          cnt_d   = hdr_cnt;
          state_d = (hdr_cnt == '0) ? DONE_ST : DATA;
        end
      end
      DATA: begin
        if (accept && asm_last) state_d = COMMIT;
      end
      COMMIT: begin
        if (addr_over) begin
          // Out-of-range write is dropped and the load is abandoned.
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          words_d = (words_q == '1) ? words_q : words_q + CNT_W'(1);
          idx_d   = idx_inc;
          wadr_d  = addr_sum[ADDR_W-1:0];
          wdat_d  = asm_word;
          state_d = (idx_inc == cnt_q) ? DONE_ST : DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the CPU stalled in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      start_hi_q <= '0;
      start_q    <= '0;
      cnt_hi_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
      wadr_q     <= '0;
      wdat_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_hi_q <= start_hi_d;
      start_q    <= start_d;
      cnt_hi_q   <= cnt_hi_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      err_q      <= err_d;
      wadr_q     <= wadr_d;
      wdat_q     <= wdat_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q inside {HDR_A0, HDR_A1, HDR_C0, HDR_C1, DATA, CHK});
`else
  assign in_ready = (state_q inside {HDR_A0, HDR_A1, HDR_C0, HDR_C1, DATA});
`endif
  assign busy          = !(state_q inside {IDLE, RUN, ERROR});
  assign cpu_en        = (state_q == RUN);
  assign error         = err_q;
  assign words_loaded  = words_q;
  assign w_enable      = commit_ok;
  // Write port shows the live commit, otherwise holds the last written values.
  assign w_adrs        = commit_ok ? addr_sum[ADDR_W-1:0] : wadr_q;
  assign w_instruction = commit_ok ? asm_word : wdat_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are built, a frame-level reference model
// predicts the writes and final outcome, writes go into exp_q and a negedge
// monitor pops and compares every w_enable pulse.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_req;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] w_instruction;
  logic [10:0] w_adrs;
  logic        w_enable;
  logic        cpu_en;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;
  logic [3:0]  dbg_state;

  int          total = 0;
  int          bad   = 0;
  logic [42:0] exp_q[$];
  logic [7:0]  frm[$];
  logic [31:0] wq[$];
  int          exp_nacc;
  int          exp_words;
  bit          exp_err;
  bit          exp_run;
  int          cyc = 0;
  int          last_wr_cyc = -100;
  int          wr_gap = 0;
  logic        prev_we = 1'b0;
  logic [42:0] mon_e;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  flip_g = 8'h00;
`endif

  program_loader dut (
    .clk           (clk),
    .resetn        (resetn),
    .load_req      (load_req),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .w_instruction (w_instruction),
    .w_adrs        (w_adrs),
    .w_enable      (w_enable),
    .cpu_en        (cpu_en),
    .busy          (busy),
    .error         (error),
    .words_loaded  (words_loaded),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor: pop expected write on every w_enable
  always @(negedge clk) begin
    if (resetn && w_enable) begin
      chk("we_single_cycle", prev_we, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got adrs %0h data %0h expected no write", w_adrs, w_instruction);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {w_adrs, w_instruction}, mon_e);
      end
      wr_gap      = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
    end
    prev_we = w_enable;
  end

  // frame builder: header + words from wq (+ checksum byte)
  task automatic build_frame(input int start, input int n);
    logic [7:0] x;
    logic [31:0] w;
    frm.delete();
    frm.push_back(start[15:8]);
    frm.push_back(start[7:0]);
    frm.push_back(n[15:8]);
    frm.push_back(n[7:0]);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      frm.push_back(w[31:24]);
      frm.push_back(w[23:16]);
      frm.push_back(w[15:8]);
      frm.push_back(w[7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (frm[k]) x = x ^ frm[k];
    frm.push_back(x ^ flip_g);
`else
    x = 8'h00;
`endif
  endtask

  // reference model: predicts accepted bytes, writes, and end state
  task automatic model_frame();
    int start;
    int n;
    logic [7:0] x;
    exp_err   = 1'b0;
    exp_run   = 1'b0;
    exp_words = 0;
    start     = int'(frm[0]) * 256 + int'(frm[1]);
    exp_nacc  = 2;
    if (start > 2047) begin
      exp_err = 1'b1;
      return;
    end
    n        = int'(frm[2]) * 256 + int'(frm[3]);
    exp_nacc = 4;
    x        = frm[0] ^ frm[1] ^ frm[2] ^ frm[3];
    for (int i = 0; i < n; i++) begin
      exp_nacc += 4;
      x = x ^ frm[4+4*i] ^ frm[5+4*i] ^ frm[6+4*i] ^ frm[7+4*i];
      if (start + i > 2047) begin
        exp_err = 1'b1;
        return;
      end
      exp_q.push_back({11'(start + i), frm[4+4*i], frm[5+4*i], frm[6+4*i], frm[7+4*i]});
      exp_words++;
    end
`ifdef LOADER_CHECKSUM_EN
    exp_nacc++;
    if (frm[exp_nacc-1] != x) begin
      exp_err = 1'b1;
      return;
    end
`endif
    exp_run = 1'b1;
  endtask

  // driver: idle gap cycles, then hold byte until accepted (bounded)
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: byte %0h not accepted, expected acceptance", b);
    end
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_cpu_en", cpu_en, 1'b0);
    chk("start_error", error, 1'b0);
    chk("start_words", words_loaded, 16'd0);
  endtask

  // gap < 0 selects random 0..2 idle cycles per byte
  task automatic send_frame(input int gap);
    for (int k = 0; k < exp_nacc; k++)
      send_byte(frm[k], (gap < 0) ? $urandom_range(0, 2) : gap);
  endtask

  task automatic finish_frame(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (!busy) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_idle_timeout: busy still 1, expected 0", tag);
    end
    chk({tag, "_cpu_en"}, cpu_en, exp_run);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_words"}, words_loaded, 16'(exp_words));
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input string tag, input int start, input int n, input int gap);
    build_frame(start, n);
    model_frame();
    start_load();
    send_frame(gap);
    finish_frame(tag);
  endtask

  initial begin
    int st;
    int n;
    // reset with in_valid high
    resetn   = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_w_enable", w_enable, 1'b0);
    chk("rst_w_adrs", w_adrs, 11'd0);
    chk("rst_w_instr", w_instruction, 32'd0);
    chk("rst_words", words_loaded, 16'd0);
    resetn   = 1'b1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("idle_busy", busy, 1'b0);
    chk("idle_cpu_en", cpu_en, 1'b0);
    chk("idle_in_ready", in_ready, 1'b0);

    // basic frame, back-to-back bytes
    wq = '{32'h0000_0123, 32'hFFFF_FFFE};
    build_frame(1, 2);
    model_frame();
    start_load();
    send_frame(0);
`ifndef LOADER_CHECKSUM_EN
    chk("basic_commit_we", w_enable, 1'b1);
    chk("basic_commit_cpu_en", cpu_en, 1'b0);
    @(posedge clk);
    #1;
    chk("basic_run_cpu_en", cpu_en, 1'b1);
`endif
    finish_frame("basic");
    chk("basic_write_gap", wr_gap, 5);

    // same frame, 3 idle cycles before every byte
    run_frame("stall", 1, 2, 3);

    // boundary: last word beyond 2047 is suppressed
    wq = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    run_frame("top_edge", 16'h07FF, 2, 0);
    // start address out of range, loaded from ERROR
    run_frame("bad_start", 16'h0800, 1, 1);
    // zero-word frame
    run_frame("n_zero", 100, 0, 0);
    // reload from RUN
    wq = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    run_frame("reload", 500, 3, 1);

    // reset after two payload bytes: no write, back to IDLE
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    #3;
    resetn = 1'b0;
    #1;
    chk("midrst_cpu_en", cpu_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_words", words_loaded, 16'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    // next frame must start on a clean word boundary
    wq = '{32'h0102_0304, 32'hA0B0_C0D0};
    run_frame("after_rst", 16, 2, 0);

`ifdef LOADER_CHECKSUM_EN
    wq = '{32'h0000_000A};
    flip_g = 8'h00;
    run_frame("chk_good", 1, 1, 0);
    flip_g = 8'h01;
    run_frame("chk_bad", 1, 1, 0);
    flip_g = 8'h00;
`endif

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 7) == 0) st = $urandom_range(2048, 65535);
      else if ($urandom_range(0, 2) == 0) st = 2047 - $urandom_range(0, 3);
      else st = $urandom_range(0, 2047);
      n = $urandom_range(0, 4);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
      flip_g = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
`endif
      run_frame("rand", st, n, -1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
